// File: rtl/fighter_sprite_pkg.sv
// Pose/state types and per-pose animation tables for the fighter sprite engine.
// BASE entries are in whole-frame units; the top scales them by the frame size.
package fighter_sprite_pkg;

    typedef enum logic [3:0] {
        POSE_STAND    = 4'd0,
        POSE_PULSE    = 4'd1,
        POSE_PUNCH    = 4'd2,
        POSE_JUMP     = 4'd3,
        POSE_CROUCH   = 4'd4,
        POSE_WALK_L   = 4'd5,
        POSE_WALK_R   = 4'd6,
        POSE_DEATH    = 4'd7,
        POSE_JUMP_ATK = 4'd8
    } pose_e;

    typedef enum logic [1:0] {
        S_LOOP    = 2'd0,
        S_ONESHOT = 2'd1,
        S_DEAD    = 2'd2
    } state_e;

    localparam int PIX_IDX_W    = 4;
    localparam int TOTAL_FRAMES = 24;

    // Class of each pose expressed as the FSM state it runs in.
    localparam state_e POSE_CLASS [16] = '{
        S_LOOP, S_ONESHOT, S_ONESHOT, S_LOOP, S_LOOP, S_LOOP, S_LOOP, S_DEAD,
        S_ONESHOT, S_LOOP, S_LOOP, S_LOOP, S_LOOP, S_LOOP, S_LOOP, S_LOOP
    };

    localparam logic [3:0] FRAME_CNT [16] = '{
        4'd2, 4'd2, 4'd3, 4'd2, 4'd1, 4'd4, 4'd4, 4'd4,
        4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2
    };

    localparam logic [7:0] BASE [16] = '{
        8'd0, 8'd2, 8'd4, 8'd7, 8'd9, 8'd10, 8'd14, 8'd18,
        8'd22, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0
    };

    function automatic logic [3:0] canon_pose(input logic [3:0] p);
        if (p > 4'(POSE_JUMP_ATK)) begin
            return 4'(POSE_STAND);
        end else begin
            return p;
        end
    endfunction

endpackage

// File: rtl/fighter_sprite_rom.sv
// Shared sprite ROM (all poses and frames) plus palette LUT, one registered read stage.
// The ROM image is a fixed nibble-fold pattern of the address so it needs no load file.
module fighter_sprite_rom
    import fighter_sprite_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [11:0]       rgb_o,
    output logic              opaque_o
);
    localparam int NIB = (ADDR_W + PIX_IDX_W - 1) / PIX_IDX_W;

    function automatic logic [PIX_IDX_W-1:0] rom_index(input logic [ADDR_W-1:0] a);
        logic [PIX_IDX_W*NIB-1:0] ext;
        logic [PIX_IDX_W-1:0]     acc;
        ext = (PIX_IDX_W*NIB)'(a);
        acc = 4'h5;
        for (int i = 0; i < NIB; i++) begin
            acc = acc ^ ext[PIX_IDX_W*i +: PIX_IDX_W];
        end
        return acc;
    endfunction

    function automatic logic [11:0] palette(input logic [PIX_IDX_W-1:0] idx);
        return {idx, ~idx, idx[2:0], 1'b0};
    endfunction

    logic [PIX_IDX_W-1:0] idx_s;
    logic                 on_s;
    logic [11:0]          rgb_q;
    logic                 opaque_q;

    always_comb begin
        idx_s = rom_index(addr_i);
        on_s  = en_i & (idx_s != 4'd0);
    end

    // Index 0 is transparent; transparent or invalid pixels output black.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_q    <= 12'd0;
            opaque_q <= 1'b0;
        end else begin
            rgb_q    <= on_s ? palette(idx_s) : 12'd0;
            opaque_q <= on_s;
        end
    end

    assign rgb_o    = rgb_q;
    assign opaque_o = opaque_q;

endmodule

// File: rtl/fighter_sprite_engine.sv
// Animated fighter sprite renderer: pose FSM, hold counter and 2-stage pixel pipeline.
// Define FIGHTER_FLIP_EN to enable horizontal mirroring via facing_left.
module fighter_sprite_engine
    import fighter_sprite_pkg::*;
#(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 96,
    parameter int MAX_FRAMES = 4,
    parameter int HOLD_TICKS = 4,
    parameter int COORD_W    = 10,
    localparam int FRAME_W   = $clog2(MAX_FRAMES)
) (
    input  logic               vga_clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic [COORD_W-1:0] PosX,
    input  logic [COORD_W-1:0] PosY,
    input  logic [3:0]         pose_req,
    input  logic               facing_left,
    input  logic               blank,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               sprite_on,
    output logic [3:0]         cur_pose,
    output logic [FRAME_W-1:0] cur_frame,
    output logic               pose_busy
);
    localparam int FRAME_PX = SPR_W * SPR_H;
    localparam int ADDR_W   = $clog2(TOTAL_FRAMES * FRAME_PX);
    localparam int HOLD_W   = $clog2(HOLD_TICKS + 1);
    localparam int RX_W     = COORD_W + 1;

    state_e             state_q;
    logic [3:0]         pose_q;
    logic [FRAME_W-1:0] frame_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               busy_q;

    logic [3:0]         req_s;
    logic               hold_done_s;
    logic               last_frame_s;
    logic [FRAME_W-1:0] frame_inc_s;

    always_comb begin
        req_s        = canon_pose(pose_req);
        hold_done_s  = (hold_q == HOLD_W'(HOLD_TICKS - 1));
        last_frame_s = (4'(frame_q) == (FRAME_CNT[pose_q] - 4'd1));
        frame_inc_s  = frame_q + 1'b1;
    end

    // Pose FSM: all updates are gated by frame_start so a frame never tears.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q <= S_LOOP;
            pose_q  <= 4'd0;
            frame_q <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
        end else if (frame_start) begin
            case (state_q)
                S_LOOP: begin
                    if (req_s != pose_q) begin
                        pose_q  <= req_s;
                        frame_q <= '0;
                        hold_q  <= '0;
                        state_q <= POSE_CLASS[req_s];
                        busy_q  <= (POSE_CLASS[req_s] != S_LOOP);
                    end else if (hold_done_s) begin
                        hold_q  <= '0;
                        frame_q <= last_frame_s ? '0 : frame_inc_s;
                    end else begin
                        hold_q  <= hold_q + 1'b1;
                    end
                end
                S_ONESHOT: begin
                    if (req_s == POSE_DEATH) begin
                        pose_q  <= 4'(POSE_DEATH);
                        frame_q <= '0;
                        hold_q  <= '0;
                        state_q <= S_DEAD;
                        busy_q  <= 1'b1;
                    end else if (hold_done_s) begin
                        hold_q <= '0;
                        if (last_frame_s) begin
                            pose_q  <= 4'(POSE_STAND);
                            frame_q <= '0;
                            state_q <= S_LOOP;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_q <= frame_inc_s;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_DEAD: begin
                    // The final death frame is held until Reset.
                    if (hold_done_s) begin
                        if (!last_frame_s) begin
                            hold_q  <= '0;
                            frame_q <= frame_inc_s;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_LOOP;
                    pose_q  <= 4'd0;
                    frame_q <= '0;
                    hold_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic signed [RX_W-1:0] rel_x_s;
    logic signed [RX_W-1:0] rel_y_s;
    logic                   hit_s;
    logic [COORD_W-1:0]     col_s;
    logic [ADDR_W-1:0]      addr_s;
    logic [ADDR_W-1:0]      addr_q;
    logic                   vld_q;

`ifndef FIGHTER_FLIP_EN
    logic unused_facing_s;
    assign unused_facing_s = facing_left;
`endif

    // Sign bit of the widened difference clips off-screen sprites without wrap.
    always_comb begin
        rel_x_s = $signed({1'b0, DrawX}) - $signed({1'b0, PosX});
        rel_y_s = $signed({1'b0, DrawY}) - $signed({1'b0, PosY});
        hit_s   = !rel_x_s[RX_W-1] && (rel_x_s[COORD_W-1:0] < COORD_W'(SPR_W)) &&
                  !rel_y_s[RX_W-1] && (rel_y_s[COORD_W-1:0] < COORD_W'(SPR_H));
`ifdef FIGHTER_FLIP_EN
        col_s   = facing_left ? (COORD_W'(SPR_W - 1) - rel_x_s[COORD_W-1:0])
                              : rel_x_s[COORD_W-1:0];
`else
        col_s   = rel_x_s[COORD_W-1:0];
`endif
        addr_s  = (ADDR_W'(BASE[pose_q]) + ADDR_W'(frame_q)) * ADDR_W'(FRAME_PX) +
                  ADDR_W'(rel_y_s[COORD_W-1:0]) * ADDR_W'(SPR_W) + ADDR_W'(col_s);
    end

    // Stage 1: register the address with hit and blank folded into one valid bit.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            addr_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            addr_q <= addr_s;
            vld_q  <= hit_s & blank;
        end
    end

    logic [11:0] rgb_s;
    logic        opaque_s;

    fighter_sprite_rom #(.ADDR_W(ADDR_W)) u_rom (
        .clk_i    (vga_clk),
        .rst_i    (Reset),
        .en_i     (vld_q),
        .addr_i   (addr_q),
        .rgb_o    (rgb_s),
        .opaque_o (opaque_s)
    );

    assign red       = rgb_s[11:8];
    assign green     = rgb_s[7:4];
    assign blue      = rgb_s[3:0];
    assign sprite_on = opaque_s;
    assign cur_pose  = pose_q;
    assign cur_frame = frame_q;
    assign pose_busy = busy_q;

endmodule

// File: tb/tb_fighter_sprite_engine.sv
// Scoreboard bench for fighter_sprite_engine: random stimulus against a tick-count pose model.
`timescale 1ns/1ps
module tb_fighter_sprite_engine;
    localparam int SPR_W = 64;
    localparam int SPR_H = 96;
    localparam int HOLD  = 4;
`ifdef FIGHTER_FLIP_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic       vga_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] DrawX = 10'd0, DrawY = 10'd0, PosX = 10'd0, PosY = 10'd0;
    logic [3:0] pose_req = 4'd0;
    logic       facing_left = 1'b0, blank = 1'b0;
    logic [3:0] red, green, blue, cur_pose;
    logic       sprite_on, pose_busy;
    logic [1:0] cur_frame;

    fighter_sprite_engine dut (
        .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
        .pose_req(pose_req), .facing_left(facing_left), .blank(blank),
        .red(red), .green(green), .blue(blue), .sprite_on(sprite_on),
        .cur_pose(cur_pose), .cur_frame(cur_frame), .pose_busy(pose_busy)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct packed { int due; logic [3:0] pose; int frame; logic busy; } st_exp_t;
    typedef struct packed { int due; logic on; logic [3:0] r; logic [3:0] g; logic [3:0] b; } px_exp_t;
    st_exp_t stq[$];
    px_exp_t pxq[$];
    int checks = 0, passed = 0;

    // Reference model: pose plus ticks elapsed since it started.
    int m_pose = 0, m_t = 0;
    int px_g = 100, py_g = 200;

    function automatic int fcnt(input int p);
        case (p)
            2: return 3;
            4: return 1;
            5, 6, 7: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int kind(input int p);  // 0 looping, 1 one-shot, 2 death
        if (p == 7) return 2;
        if (p == 1 || p == 2 || p == 8) return 1;
        return 0;
    endfunction

    function int m_frame();
        int f;
        f = m_t / HOLD;
        if (kind(m_pose) == 0) return f % fcnt(m_pose);
        if (f > fcnt(m_pose) - 1) return fcnt(m_pose) - 1;
        return f;
    endfunction

    task model_tick(input int req);
        int r;
        r = (req > 8) ? 0 : req;
        case (kind(m_pose))
            0: if (r != m_pose) begin m_pose = r; m_t = 0; end else m_t++;
            1: if (r == 7) begin m_pose = 7; m_t = 0; end
               else begin
                   m_t++;
                   if (m_t >= fcnt(m_pose) * HOLD) begin m_pose = 0; m_t = 0; end
               end
            default: if (m_t < 100000) m_t++;
        endcase
    endtask

    function automatic px_exp_t px_model(input int pose, input int frame, input int dx, input int dy,
                                          input int px, input int py, input bit bl, input bit fl);
        px_exp_t e;
        int rx, ry, col, base, a, idx;
        bit hit;
        rx = dx - px;
        ry = dy - py;
        hit = (rx >= 0) && (rx < SPR_W) && (ry >= 0) && (ry < SPR_H);
        col = (FLIP && fl) ? (SPR_W - 1 - rx) : rx;
        base = 0;
        for (int p = 0; p < pose; p++) base += fcnt(p);
        a = (base + frame) * SPR_W * SPR_H + ry * SPR_W + col;
        idx = 5;
        while (hit && a > 0) begin
            idx = idx ^ (a % 16);
            a = a / 16;
        end
        e.due = 0;
        e.on = hit && bl && (idx != 0);
        e.r = e.on ? 4'(idx) : 4'd0;
        e.g = e.on ? 4'(15 - idx) : 4'd0;
        e.b = e.on ? 4'((idx * 2) % 16) : 4'd0;
        return e;
    endfunction

    task automatic drive(input bit rst, input bit fs, input int req, input int dx, input int dy,
                         input bit bl, input bit fl);
        px_exp_t pe;
        st_exp_t se;
        @(posedge vga_clk);
        #1;
        Reset = rst; frame_start = fs; pose_req = 4'(req);
        DrawX = 10'(dx); DrawY = 10'(dy); PosX = 10'(px_g); PosY = 10'(py_g);
        blank = bl; facing_left = fl;
        if (rst) begin
            for (int i = 0; i < pxq.size(); i++) begin
                if (pxq[i].due > cyc) begin
                    px_exp_t t = pxq[i];
                    t.on = 1'b0; t.r = 4'd0; t.g = 4'd0; t.b = 4'd0;
                    pxq[i] = t;
                end
            end
            m_pose = 0; m_t = 0;
            pe = px_model(0, 0, 0, 0, 1, 1, 1'b0, 1'b0);
        end else begin
            pe = px_model(m_pose, m_frame(), dx & 1023, dy & 1023, px_g, py_g, bl, fl);
            if (fs) model_tick(req);
        end
        pe.due = cyc + 2;
        se.due = cyc + 1;
        se.pose = 4'(m_pose);
        se.frame = m_frame();
        se.busy = (kind(m_pose) != 0);
        pxq.push_back(pe);
        stq.push_back(se);
    endtask

    task automatic pick(output int dx, output int dy);
        if ($urandom_range(0, 3) != 0) begin
            dx = (px_g + int'($urandom_range(0, SPR_W + 7)) - 4) & 1023;
            dy = (py_g + int'($urandom_range(0, SPR_H + 7)) - 4) & 1023;
        end else begin
            dx = int'($urandom_range(0, 1023));
            dy = int'($urandom_range(0, 1023));
        end
    endtask

    task automatic frame(input int req_fs, input int req_mid, input int len);
        int dx, dy;
        for (int i = 0; i < len; i++) begin
            pick(dx, dy);
            drive(1'b0, i == 0, (i == 0) ? req_fs : req_mid, dx, dy,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
        end
    endtask

    st_exp_t mon_s;
    px_exp_t mon_p;

    // Monitor: compare every expectation whose due cycle has arrived.
    always @(negedge vga_clk) begin
        while (stq.size() > 0 && stq[0].due <= cyc) begin
            mon_s = stq.pop_front();
            checks++;
            if (cur_pose === mon_s.pose && int'(cur_frame) == mon_s.frame && pose_busy === mon_s.busy)
                passed++;
            else
                $display("FAIL state cyc=%0d got pose=%0d frame=%0d busy=%0b want pose=%0d frame=%0d busy=%0b",
                         cyc, cur_pose, cur_frame, pose_busy, mon_s.pose, mon_s.frame, mon_s.busy);
        end
        while (pxq.size() > 0 && pxq[0].due <= cyc) begin
            mon_p = pxq.pop_front();
            checks++;
            if (sprite_on === mon_p.on && red === mon_p.r && green === mon_p.g && blue === mon_p.b)
                passed++;
            else
                $display("FAIL pixel cyc=%0d got on=%0b rgb=%h%h%h want on=%0b rgb=%h%h%h",
                         cyc, sprite_on, red, green, blue, mon_p.on, mon_p.r, mon_p.g, mon_p.b);
        end
    end

    initial begin
        repeat (3) drive(1'b1, 1'b0, 0, 100, 200, 1'b1, 1'b0);
        // Stand at (100,200): corners, just outside, blanked, and a mirrored pair.
        drive(1'b0, 1'b1, 0, 100, 200, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 99, 200, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 100, 200, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 163, 295, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 164, 200, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 100, 296, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 100, 210, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 0, 163, 210, 1'b1, 1'b0);
        repeat (2) frame(0, 0, 4);
        // Looping walk with a wrap, mid-frame request changes ignored until the next pulse.
        repeat (20) frame(5, 3, 4);
        // Punch one-shot with a crouch request ignored while busy.
        frame(2, 0, 4);
        repeat (4) frame(0, 4, 4);
        repeat (2) frame(4, 0, 4);
        repeat (9) frame(0, 0, 4);
        // Jump-attack preempted by death, then death held, then Reset with frame_start.
        repeat (2) frame(8, 8, 3);
        frame(7, 7, 3);
        repeat (55) frame(int'($urandom_range(0, 15)), 0, 3);
        drive(1'b1, 1'b1, 7, 0, 0, 1'b1, 1'b0);
        repeat (3) frame(0, 0, 3);
        // Clipping near the right and bottom edges and at the origin.
        px_g = 1000; py_g = 20;
        drive(1'b0, 1'b0, 0, 5, 30, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 1023, 30, 1'b1, 1'b0);
        repeat (4) frame(6, 6, 5);
        px_g = 0; py_g = 990;
        repeat (4) frame(3, 3, 5);
        // Random phase.
        for (int f = 0; f < 150; f++) begin
            int req;
            if (f % 10 == 0) begin
                px_g = int'($urandom_range(0, 1023));
                py_g = int'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 59) == 0)
                drive(1'b1, $urandom_range(0, 1) == 1, 0, 0, 0, 1'b1, 1'b0);
            req = ($urandom_range(0, 39) == 0) ? 7 : int'($urandom_range(0, 15));
            if (req == 7 && $urandom_range(0, 1) == 0) req = 2;
            frame(req, int'($urandom_range(0, 15)), int'($urandom_range(3, 6)));
        end
        repeat (4) drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && (stq.size() > 0 || pxq.size() > 0); k++) @(negedge vga_clk);
        #2;
        if (stq.size() > 0 || pxq.size() > 0) begin
            checks++;
            $display("FAIL drain got pending=%0d want pending=0", stq.size() + pxq.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
